// File: rtl/alarm_pkg.sv
// Shared state encoding, adjust-field indices and sizing helper
// for the alarm mode controller.
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_ADJUST = 2'd0,
    ST_RUN    = 2'd1,
    ST_RING   = 2'd2,
    ST_SNOOZE = 2'd3
  } state_e;

  localparam int TIME_HR  = 0;
  localparam int TIME_MIN = 1;
  localparam int ALM_BASE = 2;

  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/tick_counter.sv
// Loadable saturating up/down seconds counter, shared by the
// ring timeout and the snooze delay.
module tick_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         cnt_up,
  input  logic         cnt_dn,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (tick && cnt_up && count_q != '1) begin
      count_d = count_q + W'(1);
    end else if (tick && cnt_dn && count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/alarm_mode_ctrl.sv
// Alarm clock mode controller: adjust/run/ring/snooze sequencing,
// per-alarm arming and one-shot-per-match ring suppression.
module alarm_mode_ctrl
  import alarm_pkg::*;
#(
  parameter int NUM_ALARMS   = 2,
  parameter int RING_TIMEOUT = 60,
  parameter int SNOOZE_TICKS = 300,
  parameter int NF           = ALM_BASE + 2 * NUM_ALARMS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick_1hz,
  input  logic                  up,
  input  logic                  down,
  input  logic                  left,
  input  logic                  right,
  input  logic                  center,
  input  logic [NUM_ALARMS-1:0] match,
  input  logic [NUM_ALARMS-1:0] arm_tgl,
  output logic                  adjust,
  output logic [NF-1:0]         field_sel,
  output logic                  clock_run,
  output logic                  led,
  output logic                  snoozing,
  output logic [1:0]            ring_id,
  output logic [NUM_ALARMS-1:0] armed
);

  localparam int CW = cnt_width(RING_TIMEOUT, SNOOZE_TICKS);
  localparam int FW = $clog2(NF);

  state_e                state_q, state_d;
  logic [FW-1:0]         field_q, field_d;
  logic [1:0]            ring_id_q, ring_id_d;
  logic [NUM_ALARMS-1:0] armed_q, armed_d;
  logic [NUM_ALARMS-1:0] served_q, served_d;

  logic                  adjust_q;
  logic [NF-1:0]         field_sel_q;
  logic                  clock_run_q;
  logic                  led_q;
  logic                  snoozing_q;

  logic [NUM_ALARMS-1:0] trig, other, ring_mask, served_set;
  logic                  disarm, btn_dismiss, btn_snooze;
  logic                  cnt_load, cnt_up, cnt_dn;
  logic [CW-1:0]         cnt_val, cnt;

  function automatic logic [1:0] lowest(
    input logic [NUM_ALARMS-1:0] v
  );
    logic [1:0] idx;
    idx = '0;
    for (int k = NUM_ALARMS - 1; k >= 0; k--) begin
      if (v[k]) idx = 2'(k);
    end
    return idx;
  endfunction

  tick_counter #(.W(CW)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick_1hz),
    .load     (cnt_load),
    .load_val (cnt_val),
    .cnt_up   (cnt_up),
    .cnt_dn   (cnt_dn),
    .count    (cnt)
  );

  always_comb begin
    for (int k = 0; k < NUM_ALARMS; k++) begin
      ring_mask[k] = (ring_id_q == 2'(k));
    end
    trig        = match & armed_q & ~served_q;
    other       = trig & ~ring_mask;
    disarm      = |(arm_tgl & armed_q & ring_mask);
    btn_dismiss = center | left | right;
    btn_snooze  = up | down;

    state_d    = state_q;
    field_d    = field_q;
    ring_id_d  = ring_id_q;
    armed_d    = armed_q ^ arm_tgl;
    served_set = '0;
    cnt_load   = 1'b0;
    cnt_val    = '0;
    cnt_up     = 1'b0;
    cnt_dn     = 1'b0;

    unique case (state_q)
      ST_ADJUST: begin
        if (right) begin
          field_d = (field_q == FW'(NF - 1)) ? '0 : field_q + FW'(1);
        end else if (left) begin
          field_d = (field_q == '0) ? FW'(NF - 1) : field_q - FW'(1);
        end else if (center) begin
          // alarms already matching must not ring on entry
          served_set = match;
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        if (|trig) begin
          state_d   = ST_RING;
          ring_id_d = lowest(trig);
          cnt_load  = 1'b1;
        end else if (center) begin
          state_d = ST_ADJUST;
          field_d = FW'(TIME_HR);
        end
      end
      ST_RING: begin
        if (disarm) begin
          state_d = ST_RUN;
        end else if (btn_dismiss) begin
          served_set = ring_mask;
          state_d    = ST_RUN;
        end else if (btn_snooze) begin
          served_set = ring_mask;
          cnt_load   = 1'b1;
          cnt_val    = CW'(SNOOZE_TICKS);
          state_d    = ST_SNOOZE;
        end else if (tick_1hz && cnt == CW'(RING_TIMEOUT - 1)) begin
          served_set = ring_mask;
          state_d    = ST_RUN;
        end else begin
          cnt_up = 1'b1;
        end
      end
      ST_SNOOZE: begin
        if (disarm || center) begin
          state_d = ST_RUN;
        end else if (|other) begin
          state_d   = ST_RING;
          ring_id_d = lowest(other);
          cnt_load  = 1'b1;
        end else if (tick_1hz && cnt == CW'(1)) begin
          state_d  = ST_RING;
          cnt_load = 1'b1;
        end else begin
          cnt_dn = 1'b1;
        end
      end
      default: state_d = ST_ADJUST;
    endcase

    served_d = (served_q | served_set) & match;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ADJUST;
      field_q     <= FW'(TIME_HR);
      ring_id_q   <= '0;
      armed_q     <= '0;
      served_q    <= '0;
      adjust_q    <= 1'b1;
      field_sel_q <= NF'(1);
      clock_run_q <= 1'b0;
      led_q       <= 1'b0;
      snoozing_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      field_q     <= field_d;
      ring_id_q   <= ring_id_d;
      armed_q     <= armed_d;
      served_q    <= served_d;
      adjust_q    <= (state_d == ST_ADJUST);
      field_sel_q <= (state_d == ST_ADJUST) ? (NF'(1) << field_d) : '0;
      clock_run_q <= (state_d != ST_ADJUST);
      led_q       <= (state_d == ST_RING);
      snoozing_q  <= (state_d == ST_SNOOZE);
    end
  end

  assign adjust    = adjust_q;
  assign field_sel = field_sel_q;
  assign clock_run = clock_run_q;
  assign led       = led_q;
  assign snoozing  = snoozing_q;
  assign ring_id   = ring_id_q;
  assign armed     = armed_q;

endmodule

// File: tb/tb_alarm_mode_ctrl.sv
// Directed and random checks of alarm_mode_ctrl against a
// behavioural mode model (2 alarms, 3 s ring, 2 s snooze).
module tb_alarm_mode_ctrl;

  localparam int NA  = 2;
  localparam int RT  = 3;
  localparam int SNZ = 2;
  localparam int NF  = 2 + 2 * NA;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tick_1hz = 1'b0;
  logic          up = 1'b0, down = 1'b0;
  logic          left = 1'b0, right = 1'b0;
  logic          center = 1'b0;
  logic [NA-1:0] match = '0;
  logic [NA-1:0] arm_tgl = '0;
  logic          adjust, clock_run, led, snoozing;
  logic [NF-1:0] field_sel;
  logic [1:0]    ring_id;
  logic [NA-1:0] armed;

  int checks = 0;
  int failures = 0;

  typedef enum int {M_ADJ, M_RUN, M_RING, M_SNZ} mode_t;
  mode_t    m_st;
  int       m_field, m_rid, m_el, m_rem;
  bit [1:0] m_arm, m_srv;

  alarm_mode_ctrl #(
    .NUM_ALARMS   (NA),
    .RING_TIMEOUT (RT),
    .SNOOZE_TICKS (SNZ)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tick_1hz  (tick_1hz),
    .up        (up),
    .down      (down),
    .left      (left),
    .right     (right),
    .center    (center),
    .match     (match),
    .arm_tgl   (arm_tgl),
    .adjust    (adjust),
    .field_sel (field_sel),
    .clock_run (clock_run),
    .led       (led),
    .snoozing  (snoozing),
    .ring_id   (ring_id),
    .armed     (armed)
  );

  always #5 clk = ~clk;

  function automatic int low(input bit [1:0] v);
    return v[0] ? 0 : 1;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model();
    bit [1:0] trig, oth, rm, nsv;
    bit       dis;
    if (rst) begin
      m_st = M_ADJ; m_field = 0; m_rid = 0;
      m_arm = 0; m_srv = 0; m_el = 0; m_rem = 0;
      return;
    end
    trig = match & m_arm & ~m_srv;
    rm   = 2'(1 << m_rid);
    oth  = trig & ~rm;
    dis  = (arm_tgl & m_arm & rm) != 0;
    nsv  = m_srv;
    m_arm = m_arm ^ arm_tgl;
    case (m_st)
      M_ADJ:
        if (right) m_field = (m_field + 1) % NF;
        else if (left) m_field = (m_field + NF - 1) % NF;
        else if (center) begin nsv |= match; m_st = M_RUN; end
      M_RUN:
        if (trig != 0) begin
          m_st = M_RING; m_rid = low(trig); m_el = 0;
        end else if (center) begin
          m_st = M_ADJ; m_field = 0;
        end
      M_RING:
        if (dis) m_st = M_RUN;
        else if (center || left || right) begin
          nsv |= rm; m_st = M_RUN;
        end else if (up || down) begin
          nsv |= rm; m_rem = SNZ; m_st = M_SNZ;
        end else if (tick_1hz) begin
          m_el++;
          if (m_el == RT) begin nsv |= rm; m_st = M_RUN; end
        end
      M_SNZ:
        if (dis || center) m_st = M_RUN;
        else if (oth != 0) begin
          m_st = M_RING; m_rid = low(oth); m_el = 0;
        end else if (tick_1hz) begin
          if (m_rem == 1) begin m_st = M_RING; m_el = 0; end
          else m_rem--;
        end
      default: m_st = M_ADJ;
    endcase
    m_srv = nsv & match;
  endtask

  task automatic step();
    logic [7:0] fs;
    model();
    @(posedge clk);
    #1;
    fs = (m_st == M_ADJ) ? 8'(1 << m_field) : 8'h00;
    chk("adjust", 8'(adjust), 8'(m_st == M_ADJ));
    chk("field_sel", 8'(field_sel), fs);
    chk("clock_run", 8'(clock_run), 8'(m_st != M_ADJ));
    chk("led", 8'(led), 8'(m_st == M_RING));
    chk("snoozing", 8'(snoozing), 8'(m_st == M_SNZ));
    chk("ring_id", 8'(ring_id), 8'(m_rid));
    chk("armed", 8'(armed), 8'(m_arm));
    rst = 0; tick_1hz = 0; arm_tgl = '0;
    up = 0; down = 0; left = 0; right = 0; center = 0;
  endtask

  initial begin
    rst = 1; step();
    chk("rst_fs", 8'(field_sel), 8'h01);
    chk("rst_cr", 8'(clock_run), 8'h00);

    for (int i = 0; i < 6; i++) begin right = 1; step(); end
    chk("fs_wrap", 8'(field_sel), 8'h01);
    left = 1; step();
    chk("fs_left", 8'(field_sel), 8'h20);

    center = 1; step();
    arm_tgl = 2'b11; step();
    match = 2'b11; step();
    chk("r0_led", 8'(led), 8'h01);
    chk("r0_id", 8'(ring_id), 8'h00);
    center = 1; step();
    step();
    chk("r1_id", 8'(ring_id), 8'h01);
    center = 1; step();
    match = 2'b00; step();

    match = 2'b01; step();
    for (int i = 0; i < RT; i++) begin tick_1hz = 1; step(); end
    chk("tmo_led", 8'(led), 8'h00);
    step(); step();
    chk("no_rering", 8'(led), 8'h00);
    match = 2'b00; step();
    match = 2'b01; step();
    chk("rering", 8'(led), 8'h01);

    up = 1; step();
    chk("snz", 8'(snoozing), 8'h01);
    for (int i = 0; i < SNZ; i++) begin tick_1hz = 1; step(); end
    chk("snz_ring", 8'(led), 8'h01);
    arm_tgl = 2'b01; step();
    chk("disarm", 8'(armed), 8'h02);
    chk("disarm_led", 8'(led), 8'h00);

    match = 2'b00; center = 1; step();
    arm_tgl = 2'b01; step();
    match = 2'b01; step();
    center = 1; step();
    step(); step();
    chk("enter_run", 8'(led), 8'h00);
    match = 2'b00; step();
    match = 2'b01; step();
    rst = 1; step();
    chk("rst_ring", 8'(adjust), 8'h01);

    for (int i = 0; i < 3000; i++) begin
      tick_1hz = ($urandom % 3) == 0;
      up       = ($urandom % 20) == 0;
      down     = ($urandom % 30) == 0;
      left     = ($urandom % 20) == 0;
      right    = ($urandom % 20) == 0;
      center   = ($urandom % 14) == 0;
      arm_tgl  = 2'($urandom % 16 == 0) | (2'($urandom % 16 == 0) << 1);
      if ($urandom % 6 == 0) match[$urandom % 2] ^= 1'b1;
      rst      = ($urandom % 300) == 0;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alarm_mode_ctrl.md
ALARM_MODE_CTRL -- requirements
Module: alarm_mode_ctrl

Interface
REQ-001 Parameter NUM_ALARMS, default 2, number of independent alarm channels; legal range 1..4.
REQ-002 Parameter RING_TIMEOUT, default 60, tick_1hz pulses of ringing before auto-silence; minimum 1.
REQ-003 Parameter SNOOZE_TICKS, default 300, tick_1hz pulses of snooze before re-ring; minimum 1.
REQ-004 Derived NF = 2 + 2*NUM_ALARMS adjust fields: 0 = time hour, 1 = time minute, 2+2k = alarm k hour, 3+2k = alarm k minute.
REQ-005 clk  in  1  single system clock; all state changes on the rising edge.
REQ-006 rst  in  1  reset; synchronous, active-high.
REQ-007 tick_1hz  in  1  one-cycle pulse once per second.
REQ-008 up, down, left, right, center  in  1 each  debounced one-cycle button pulses.
REQ-009 match  in  NUM_ALARMS  level; bit k high while current time equals alarm k time.
REQ-010 arm_tgl  in  NUM_ALARMS  one-cycle pulse; toggles armed[k].
REQ-011 adjust  out  1  high in ADJUST.
REQ-012 field_sel  out  NF  one-hot selected adjust field; all zero outside ADJUST.
REQ-013 clock_run  out  1  time-counter enable; high in RUN, RING, SNOOZE.
REQ-014 led  out  1  high in RING.
REQ-015 snoozing  out  1  high in SNOOZE.
REQ-016 ring_id  out  2  index of ringing/snoozed alarm; holds last value elsewhere.
REQ-017 armed  out  NUM_ALARMS  per-alarm arm flags.

Function
REQ-018 States ADJUST, RUN, RING, SNOOZE; all outputs registered or decoded from registered state only.
REQ-019 ADJUST: right -> field+1 mod NF; else left -> field-1 mod NF; else center -> RUN; priority right > left > center.
REQ-020 Per-alarm served[k] flag; trigger[k] = match[k] & armed[k] & ~served[k]; served[k] clears in any cycle match[k] is low.
REQ-021 On ADJUST->RUN transition, served[k] is set for every k with match[k]=1 (no ring on entering RUN mid-match).
REQ-022 RUN: any trigger -> RING, ring_id = lowest triggering index, ring counter = 0; else center -> ADJUST with field 0; trigger beats center.
REQ-023 RING: counter increments on tick_1hz; center, left or right -> dismiss (served[ring_id]=1, -> RUN); up or down -> snooze (served[ring_id]=1, counter = SNOOZE_TICKS, -> SNOOZE).
REQ-024 RING: counter reaching RING_TIMEOUT -> served[ring_id]=1, -> RUN; a button in the same cycle takes priority.
REQ-025 SNOOZE: counter decrements on tick_1hz; tick with counter = 1 -> RING, same ring_id, counter = 0; center -> RUN (snooze cancelled).
REQ-026 SNOOZE: trigger of another alarm -> RING with that id; the snoozed alarm is abandoned.
REQ-027 arm_tgl[k] toggles armed[k] in every state; if k = ring_id in RING or SNOOZE, the resulting disarm -> RUN.
REQ-028 Matches of other alarms during RING are not queued; they ring from RUN only if still triggering.
REQ-029 Counter width = clog2(max(RING_TIMEOUT, SNOOZE_TICKS)+1); no wrap permitted.

Reset
REQ-030 rst: state ADJUST, field 0, armed all 0, served all 0, counter 0, ring_id 0; outputs adjust=1, field_sel=1, clock_run=0, led=0, snoozing=0.
REQ-031 rst overrides every other input in the same cycle, including mid-RING and mid-SNOOZE.

Structure
REQ-032 Package alarm_pkg holds state encoding and field-index constants (TIME_HR, TIME_MIN, ALM_BASE).
REQ-033 One sub-module, tick_counter: loadable up/down counter enabled by tick_1hz, shared by ring timeout and snooze.

Verification (NUM_ALARMS=2, RING_TIMEOUT=3, SNOOZE_TICKS=2)
REQ-034 rst; right x6 -> field_sel 000010, 000100, 001000, 010000, 100000, then 000001 (wrap); left once -> 100000.
REQ-035 RUN, armed=11, match=11 same cycle -> RING, ring_id=0, led=1; center -> RUN; next cycle alarm 1 triggers -> RING, ring_id=1.
REQ-036 RING alarm 0, no buttons, 3 ticks -> RUN, led=0; match[0] held high -> no re-ring; match[0] low then high -> RING.
REQ-037 RING, up -> SNOOZE, snoozing=1; 2 ticks -> RING, ring_id unchanged; arm_tgl[0] -> armed[0]=0, RUN.
REQ-038 ADJUST with match[0]=1, armed[0]=1, center -> RUN, no RING; rst asserted during RING -> ADJUST, led=0, armed=00.
